ide_rdata_flow_ctrl: RTL and testbench

Parametrised flow-control block gating transfers from the IDE read-data FIFO into NUM_CH downstream write FIFOs. It replaces the fixed four-channel, single-threshold ack generator with three additions: per-channel almost-full hysteresis, a channel-enable mask, and fixed-length bursts of `ack` separated by a mandatory gap. It sits between the IDE read-data FIFO (read side) and the per-SSD-channel write FIFOs. The existing `ack` consumer is unchanged: one word is moved per cycle while `ack` is high.

---
 rtl/ide_rdata_flow_ctrl.sv | 154 +++++++++++++++
 tb/tb_ide_rdata_flow_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ide_rdata_flow_ctrl.sv
// Flow control from the IDE read-data FIFO into NUM_CH write FIFOs: almost-full hysteresis,
// channel-enable mask, fixed-length ack bursts with a forced gap. Optional counters: IDE_RDATA_FLOW_STATS_EN.
module ide_rdata_flow_ctrl #(
    parameter int NUM_CH    = 4,
    parameter int RD_AW     = 11,
    parameter int WR_AW     = 14,
    parameter int RD_THRESH = 100,
    parameter int WR_HI     = 8000,
    parameter int WR_LO     = 7000,
    parameter int BURST_LEN = 64,
    parameter int GAP_CYC   = 2
) (
    input  logic                      clk,
    input  logic                      nRST,
    input  logic [RD_AW-1:0]          usedw_rd,
    input  logic [NUM_CH*WR_AW-1:0]   usedw_wr,
    input  logic [NUM_CH-1:0]         ch_en,
    output logic                      ack,
    output logic                      burst_start,
    output logic                      busy,
    output logic [NUM_CH-1:0]         af
`ifdef IDE_RDATA_FLOW_STATS_EN
    ,
    output logic [15:0]               stall_cnt,
    output logic [7:0]                abort_cnt
`endif
);

    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [RD_AW-1:0] RD_THR     = RD_AW'(RD_THRESH);
    localparam logic [WR_AW-1:0] WR_HI_W    = WR_AW'(WR_HI);
    localparam logic [WR_AW-1:0] WR_LO_W    = WR_AW'(WR_LO);
    localparam logic [BW-1:0]    BURST_LOAD = BW'(BURST_LEN - 1);
    localparam logic [GW-1:0]    GAP_LOAD   = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [BW-1:0]    B_ONE      = BW'(1);
    localparam logic [GW-1:0]    G_ONE      = GW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t        state, next_state;
    logic [BW-1:0] burst_cnt, burst_cnt_nxt;
    logic [GW-1:0] gap_cnt, gap_cnt_nxt;
    logic          ack_d, burst_start_d, busy_d;
    logic          rd_above, any_af, any_en, ready, stop;

    // Handshake: ack is a one-way enable; the consumer moves exactly one word on every
    // clk edge that samples ack=1. There is no back-pressure input from the consumer.
    assign rd_above = (usedw_rd > RD_THR);
    assign any_af   = |af;
    assign any_en   = |ch_en;
    assign ready    = rd_above && any_en && !any_af;
    assign stop     = (usedw_rd == '0) || any_af || !any_en;

    // Almost-full flags with hysteresis; a disabled channel never blocks.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            af <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!ch_en[i])
                    af[i] <= 1'b0;
                else if (usedw_wr[i*WR_AW +: WR_AW] >= WR_HI_W)
                    af[i] <= 1'b1;
                else if (usedw_wr[i*WR_AW +: WR_AW] < WR_LO_W)
                    af[i] <= 1'b0;
            end
        end
    end

    // State register; outputs are registered from the next-state decode so ack is glitch-free.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state       <= IDLE;
            burst_cnt   <= '0;
            gap_cnt     <= '0;
            ack         <= 1'b0;
            burst_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= next_state;
            burst_cnt   <= burst_cnt_nxt;
            gap_cnt     <= gap_cnt_nxt;
            ack         <= ack_d;
            burst_start <= burst_start_d;
            busy        <= busy_d;
        end
    end

    always_comb begin
        next_state    = state;
        burst_cnt_nxt = burst_cnt;
        gap_cnt_nxt   = gap_cnt;
        case (state)
            IDLE: begin
                if (ready) begin
                    next_state    = BURST;
                    burst_cnt_nxt = BURST_LOAD;
                end
            end
            BURST: begin
                if (stop || burst_cnt == '0) begin
                    if (GAP_CYC > 0) begin
                        next_state  = GAP;
                        gap_cnt_nxt = GAP_LOAD;
                    end else begin
                        next_state  = IDLE;
                    end
                end else begin
                    burst_cnt_nxt = burst_cnt - B_ONE;
                end
            end
            GAP: begin
                if (gap_cnt == '0)
                    next_state  = IDLE;
                else
                    gap_cnt_nxt = gap_cnt - G_ONE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ack_d         = (next_state == BURST);
        burst_start_d = (state == IDLE) && (next_state == BURST);
        busy_d        = (next_state != IDLE);
    end

`ifdef IDE_RDATA_FLOW_STATS_EN
    logic stall_inc, abort_inc;

    assign stall_inc = (state == IDLE) && rd_above && any_af;
    // Running out of burst_cnt on the same cycle as a stop is a normal end, not an abort.
    assign abort_inc = (state == BURST) && stop && (burst_cnt != '0);

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
            abort_cnt <= '0;
        end else begin
            if (stall_inc && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (abort_inc && abort_cnt != 8'hFF)
                abort_cnt <= abort_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ide_rdata_flow_ctrl.sv
// Bench for ide_rdata_flow_ctrl: directed phases plus random traffic, checked every cycle
// against a remaining-cycles reference model.
module tb_ide_rdata_flow_ctrl;

    localparam int NUM_CH    = 4;
    localparam int RD_AW     = 11;
    localparam int WR_AW     = 14;
    localparam int RD_THRESH = 100;
    localparam int WR_HI     = 8000;
    localparam int WR_LO     = 7000;
    localparam int BURST_LEN = 64;
    localparam int GAP_CYC   = 2;

    // clock / reset
    logic clk = 1'b0;
    logic nRST = 1'b1;
    always #5 clk = ~clk;

    logic [RD_AW-1:0]        usedw_rd;
    logic [WR_AW-1:0]        cnt [NUM_CH];
    logic [NUM_CH*WR_AW-1:0] usedw_wr;
    logic [NUM_CH-1:0]       ch_en;
    logic                    ack, burst_start, busy;
    logic [NUM_CH-1:0]       af;
`ifdef IDE_RDATA_FLOW_STATS_EN
    logic [15:0]             stall_cnt;
    logic [7:0]              abort_cnt;
`endif

    assign usedw_wr = {cnt[3], cnt[2], cnt[1], cnt[0]};

    ide_rdata_flow_ctrl #(
        .NUM_CH(NUM_CH), .RD_AW(RD_AW), .WR_AW(WR_AW), .RD_THRESH(RD_THRESH),
        .WR_HI(WR_HI), .WR_LO(WR_LO), .BURST_LEN(BURST_LEN), .GAP_CYC(GAP_CYC)
    ) dut (
        .clk(clk),
        .nRST(nRST),
        .usedw_rd(usedw_rd),
        .usedw_wr(usedw_wr),
        .ch_en(ch_en),
        .ack(ack),
        .burst_start(burst_start),
        .busy(busy),
        .af(af)
`ifdef IDE_RDATA_FLOW_STATS_EN
        ,
        .stall_cnt(stall_cnt),
        .abort_cnt(abort_cnt)
`endif
    );

    // reference model: acks still owed in this burst, forced-low cycles still owed
    int              m_left;
    int              m_gap;
    bit              m_start;
    bit [NUM_CH-1:0] m_af;
    int              m_stall;
    int              m_abort;

    int vectors = 0;
    int miscompares = 0;

    task automatic model_reset();
        m_left = 0; m_gap = 0; m_start = 0; m_af = '0; m_stall = 0; m_abort = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        bit any_af, any_en, rdy, stp;
        any_af = |m_af;
        any_en = |ch_en;
        rdy = (int'(usedw_rd) > RD_THRESH) && any_en && !any_af;
        stp = (usedw_rd == 0) || any_af || !any_en;
        m_start = 0;
        if (m_left > 0) begin
            if (stp || m_left == 1) begin
                if (stp && m_left > 1 && m_abort < 255) m_abort++;
                m_left = 0;
                m_gap = GAP_CYC;
            end else begin
                m_left--;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else begin
            if (int'(usedw_rd) > RD_THRESH && any_af && m_stall < 65535) m_stall++;
            if (rdy) begin
                m_left = BURST_LEN;
                m_start = 1;
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (!ch_en[i]) m_af[i] = 0;
            else if (int'(cnt[i]) >= WR_HI) m_af[i] = 1;
            else if (int'(cnt[i]) < WR_LO) m_af[i] = 0;
        end
    endtask

    // scoreboard compare
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("ack", 32'(ack), 32'(m_left > 0));
        chk("burst_start", 32'(burst_start), 32'(m_start));
        chk("busy", 32'(busy), 32'(m_left > 0 || m_gap > 0));
        chk("af", 32'(af), 32'(m_af));
`ifdef IDE_RDATA_FLOW_STATS_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        chk("abort_cnt", 32'(abort_cnt), 32'(m_abort));
`endif
    endtask

    // driver: inputs are applied at the falling edge, outputs checked at the next one
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int run;
        usedw_rd = 11'd100;
        ch_en = 4'hF;
        for (int i = 0; i < NUM_CH; i++) cnt[i] = '0;
        model_reset();

        // reset
        #1 nRST = 1'b0;
        @(negedge clk);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(burst_start), 32'd0);
        chk("rst_af", 32'(af), 32'd0);
        @(negedge clk);
        nRST = 1'b1;

        // threshold is strict: 100 words never starts a burst
        ticks(20);
        usedw_rd = 11'd101;
        tick();
        chk("first_ack", 32'(ack), 32'd1);
        chk("first_start", 32'(burst_start), 32'd1);
        run = int'(ack);
        for (int i = 0; i < 65; i++) begin
            tick();
            if (ack) run++;
        end
        chk("burst_len", 32'(run), 32'(BURST_LEN));

        // back-to-back bursts with the forced gap
        usedw_rd = 11'd500;
        ticks(210);

        // hysteresis on channel 2
        ticks(5);
        cnt[2] = 14'd8000;
        ticks(4);
        cnt[2] = 14'd7500;
        ticks(20);
        chk("hyst_hold_af", 32'(af), 32'h4);
        cnt[2] = 14'd6999;
        ticks(80);

        // mask: a disabled channel never asserts almost-full
        ch_en = 4'b1011;
        cnt[2] = 14'd9000;
        ticks(150);
        ch_en = 4'b0000;
        ticks(10);
        chk("mask_off_ack", 32'(ack), 32'd0);

        // async reset ten cycles into a burst
        ch_en = 4'hF;
        cnt[2] = '0;
        ticks(10);
        #2 nRST = 1'b0;
        #1;
        chk("arst_ack", 32'(ack), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_af", 32'(af), 32'd0);
        model_reset();
        @(negedge clk);
        nRST = 1'b1;
        ticks(70);

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            usedw_rd = ($urandom_range(0, 9) == 0) ? 11'd0 : 11'($urandom_range(90, 300));
            for (int i = 0; i < NUM_CH; i++)
                if ($urandom_range(0, 7) == 0) cnt[i] = 14'($urandom_range(6900, 8100));
            if ($urandom_range(0, 49) == 0) ch_en = 4'($urandom_range(0, 15));
            else if ($urandom_range(0, 49) == 0) ch_en = 4'hF;
            tick();
        end

`ifdef IDE_RDATA_FLOW_STATS_EN
        // saturate the stall counter
        ch_en = 4'hF;
        usedw_rd = 11'd500;
        for (int i = 0; i < NUM_CH; i++) cnt[i] = '0;
        cnt[0] = 14'd8000;
        ticks(66000);
        chk("stall_sat", 32'(stall_cnt), 32'hFFFF);
        // saturate the abort counter: start a burst, then empty the read FIFO
        cnt[0] = '0;
        ticks(5);
        for (int n = 0; n < 300; n++) begin
            usedw_rd = 11'd500;
            ticks(2);
            usedw_rd = 11'd0;
            ticks(3);
        end
        chk("abort_sat", 32'(abort_cnt), 32'hFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
